// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared sizes, FSM state type and priority encoder for the min sort engine
package sort_pkg;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int IW = $clog2(N);
  // Bit counter width; a 1-bit element still needs a 1-bit counter.
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PRESENT
  } sort_state_t;

  // Lowest set bit wins, so equal candidates resolve to the lowest index.
  function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) begin
        idx = IW'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/min_bit_step.sv
// rtl/min_bit_step.sv - one MSB-first elimination step over the candidate mask
module min_bit_step
  import sort_pkg::*;
(
  input  logic [N-1:0] cand,
  input  logic [N-1:0] bit_slice,
  output logic [N-1:0] next_cand,
  output logic         any_zero
);

  // Candidates with a 0 at this bit are strictly smaller than those with a 1.
  always_comb begin
    next_cand = cand & ~bit_slice;
    any_zero  = |next_cand;
  end

endmodule

// File: rtl/min_extract_seq.sv
// rtl/min_extract_seq.sv - bit-serial minimum extraction, emits a loaded job in ascending order
module min_extract_seq
  import sort_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_valid,
  input  logic [N*W-1:0]    i_load_data,
  output logic              o_load_ready,
  output logic              o_valid,
  output logic [W-1:0]      o_data,
  output logic [IW-1:0]     o_idx,
  output logic              o_last,
  input  logic              i_ready
);

  sort_state_t            state_q, state_d;
  logic [N-1:0][W-1:0]    data_q, data_d;
  logic [N-1:0]           alive_q, alive_d;
  logic [N-1:0]           cand_q, cand_d;
  logic [BW-1:0]          b_q, b_d;
  logic [IW-1:0]          emit_q, emit_d;
  logic                   o_valid_q, o_valid_d;
  logic [W-1:0]           o_data_q, o_data_d;
  logic [IW-1:0]          o_idx_q, o_idx_d;
  logic                   o_last_q, o_last_d;

  logic [N-1:0]           slice;
  logic [N-1:0]           step_next;
  logic                   step_any_zero;
  logic [N-1:0]           scan_cand;
  logic [IW-1:0]          scan_sel;
  logic [N-1:0]           sel_mask;

  // Gather bit b of every stored element for the elimination step.
  always_comb begin
    slice = '0;
    for (int k = 0; k < N; k++) begin
      slice[k] = data_q[k][b_q];
    end
  end

  min_bit_step u_step (
    .cand      (cand_q),
    .bit_slice (slice),
    .next_cand (step_next),
    .any_zero  (step_any_zero)
  );

  // Candidate mask after this bit, and the winner once the last bit is done.
  always_comb begin
    scan_cand = step_any_zero ? step_next : cand_q;
    scan_sel  = lowest_set(scan_cand);
    sel_mask  = N'(1) << o_idx_q;
  end

  // Next-state and datapath updates for load, scan and present.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    alive_d   = alive_q;
    cand_d    = cand_q;
    b_d       = b_q;
    emit_d    = emit_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_idx_d   = o_idx_q;
    o_last_d  = o_last_q;

    case (state_q)
      ST_IDLE: begin
        if (i_load_valid) begin
          data_d  = i_load_data;
          alive_d = '1;
          cand_d  = '1;
          b_d     = BW'(W - 1);
          emit_d  = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        cand_d = scan_cand;
        if (b_q == '0) begin
          // Outputs are loaded here so o_valid comes straight from a flop.
          o_valid_d = 1'b1;
          o_data_d  = data_q[scan_sel];
          o_idx_d   = scan_sel;
          o_last_d  = (emit_q == IW'(N - 1));
          state_d   = ST_PRESENT;
        end else begin
          b_d = b_q - 1'b1;
        end
      end

      ST_PRESENT: begin
        if (i_ready) begin
          o_valid_d = 1'b0;
          emit_d    = emit_q + 1'b1;
          b_d       = BW'(W - 1);
          if (o_last_q) begin
            alive_d = '0;
            cand_d  = '0;
            state_d = ST_IDLE;
          end else begin
            alive_d = alive_q & ~sel_mask;
            cand_d  = alive_q & ~sel_mask;
            state_d = ST_SCAN;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        o_valid_d = 1'b0;
        alive_d   = '0;
      end
    endcase
  end

  // State and output registers; reset drops any job in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      alive_q   <= '0;
      cand_q    <= '0;
      b_q       <= '0;
      emit_q    <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_idx_q   <= '0;
      o_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      alive_q   <= alive_d;
      cand_q    <= cand_d;
      b_q       <= b_d;
      emit_q    <= emit_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_idx_q   <= o_idx_d;
      o_last_q  <= o_last_d;
    end
  end

  assign o_load_ready = (state_q == ST_IDLE);
  assign o_valid      = o_valid_q;
  assign o_data       = o_data_q;
  assign o_idx        = o_idx_q;
  assign o_last       = o_last_q;

endmodule
